pcap_replay_sequencer: RTL and testbench

- Parametrised, multi-queue successor to the single-range replay controller.
- Per queue: walks a programmed QDR address window [addr_low, addr_high) in fixed steps and issues one read request per step, round-robin across queues.
- Repeats each window a programmed number of times; a count of 0 means continuous replay.
- Sits between the AXI-Lite register file and the QDR read port. Bounds in-flight reads with a credit counter.

---
 rtl/pcap_replay_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_pcap_replay_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pcap_replay_sequencer.sv
// Multi-queue QDR replay sequencer: walks per-queue address windows in fixed
// steps, issues round-robin read requests and bounds in-flight reads by credit.
module pcap_replay_sequencer #(
  parameter int unsigned NUM_QUEUES      = 4,
  parameter int unsigned ADDR_WIDTH      = 19,
  parameter int unsigned COUNT_WIDTH     = 32,
  parameter int unsigned ADDR_STEP       = 2,
  parameter int unsigned MAX_OUTSTANDING = 16,
  localparam int unsigned QidWidth = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1,
  localparam int unsigned OutWidth = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                              axi_aclk,
  input  logic                              sw_rst,
  input  logic                              start_replay,
  input  logic [NUM_QUEUES-1:0]             q_enable,
  input  logic [NUM_QUEUES*ADDR_WIDTH-1:0]  q_addr_low,
  input  logic [NUM_QUEUES*ADDR_WIDTH-1:0]  q_addr_high,
  input  logic [NUM_QUEUES*COUNT_WIDTH-1:0] q_replay_count,
  output logic                              rd_req_valid,
  input  logic                              rd_req_ready,
  output logic [ADDR_WIDTH-1:0]             rd_req_addr,
  output logic [QidWidth-1:0]               rd_req_qid,
  input  logic                              rd_rsp_valid,
  output logic                              busy,
  output logic [NUM_QUEUES-1:0]             q_done,
  output logic [NUM_QUEUES-1:0]             q_cfg_err,
  output logic [NUM_QUEUES*COUNT_WIDTH-1:0] q_passes
);

  typedef enum logic [2:0] {StIdle, StLoad, StRun, StDrain, StDone} state_e;

  state_e state_q, state_d;
  logic   start_q;
  logic   start_rise;

  logic [NUM_QUEUES-1:0]  done_q, done_d;
  logic [NUM_QUEUES-1:0]  cfg_err_q, cfg_err_d;
  logic [ADDR_WIDTH-1:0]  low_q    [NUM_QUEUES];
  logic [ADDR_WIDTH-1:0]  high_q   [NUM_QUEUES];
  logic [COUNT_WIDTH-1:0] count_q  [NUM_QUEUES];
  logic [ADDR_WIDTH-1:0]  cur_q    [NUM_QUEUES];
  logic [ADDR_WIDTH-1:0]  cur_d    [NUM_QUEUES];
  logic [COUNT_WIDTH-1:0] passes_q [NUM_QUEUES];
  logic [COUNT_WIDTH-1:0] passes_d [NUM_QUEUES];
  logic [QidWidth-1:0]    rr_q, rr_d;
  logic [OutWidth-1:0]    out_q, out_d;

  logic                   grant_found;
  logic [QidWidth-1:0]    grant_idx;
  logic [QidWidth-1:0]    scan_idx;
  logic                   credit_ok;
  logic                   accept;
  logic                   rsp_take;
  logic                   all_done;
  logic [ADDR_WIDTH:0]    next_addr;
  logic [COUNT_WIDTH-1:0] passes_inc;

  assign start_rise = start_replay & ~start_q;
  assign all_done   = &done_q;
  assign credit_ok  = out_q < OutWidth'(MAX_OUTSTANDING);
  // Responses with nothing outstanding (e.g. after a reset) are dropped.
  assign rsp_take   = rd_rsp_valid && (out_q != '0);

  // Round-robin grant: first not-done queue at or after the pointer.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int unsigned k = 0; k < NUM_QUEUES; k++) begin
      scan_idx = QidWidth'((32'(rr_q) + k) % NUM_QUEUES);
      if (!grant_found && !done_q[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  // Request outputs; dropping start_replay withdraws the request in the exit cycle.
  always_comb begin
    rd_req_valid = (state_q == StRun) && start_replay && grant_found && credit_ok;
    rd_req_addr  = cur_q[grant_idx];
    rd_req_qid   = grant_idx;
    accept       = rd_req_valid && rd_req_ready;
    busy         = (state_q == StLoad) || (state_q == StRun) || (state_q == StDrain);
    q_done       = done_q;
    q_cfg_err    = cfg_err_q;
    q_passes     = '0;
    for (int unsigned i = 0; i < NUM_QUEUES; i++) begin
      q_passes[i*COUNT_WIDTH +: COUNT_WIDTH] = passes_q[i];
    end
  end

  // FSM next-state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_rise) state_d = StLoad;
      StLoad:  state_d = StRun;
      StRun:   if (!start_replay || all_done) state_d = StDrain;
      StDrain: if (out_q == '0) state_d = StDone;
      StDone:  if (!start_replay) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Credit counter next-state; simultaneous accept and response cancel.
  always_comb begin
    out_d = out_q;
    if (accept && !rsp_take) begin
      out_d = out_q + OutWidth'(1);
    end else if (!accept && rsp_take) begin
      out_d = out_q - OutWidth'(1);
    end
  end

  // Per-queue walk state: initialised in LOAD, advanced on each accept.
  always_comb begin
    cur_d      = cur_q;
    passes_d   = passes_q;
    done_d     = done_q;
    cfg_err_d  = cfg_err_q;
    rr_d       = rr_q;
    next_addr  = '0;
    passes_inc = '0;
    if (state_q == StLoad) begin
      rr_d = '0;
      for (int unsigned i = 0; i < NUM_QUEUES; i++) begin
        cur_d[i]     = q_addr_low[i*ADDR_WIDTH +: ADDR_WIDTH];
        passes_d[i]  = '0;
        cfg_err_d[i] = q_enable[i] && (q_addr_high[i*ADDR_WIDTH +: ADDR_WIDTH] <=
                                       q_addr_low[i*ADDR_WIDTH +: ADDR_WIDTH]);
        done_d[i]    = !q_enable[i] || cfg_err_d[i];
      end
    end else if (accept) begin
      // One extra bit so a window ending near the top of memory still wraps.
      next_addr  = {1'b0, cur_q[grant_idx]} + (ADDR_WIDTH+1)'(ADDR_STEP);
      passes_inc = passes_q[grant_idx] + COUNT_WIDTH'(1);
      if (next_addr >= {1'b0, high_q[grant_idx]}) begin
        cur_d[grant_idx] = low_q[grant_idx];
        if (passes_q[grant_idx] != '1) passes_d[grant_idx] = passes_inc;
        if ((count_q[grant_idx] != '0) && (passes_inc == count_q[grant_idx])) begin
          done_d[grant_idx] = 1'b1;
        end
      end else begin
        cur_d[grant_idx] = next_addr[ADDR_WIDTH-1:0];
      end
      rr_d = (32'(grant_idx) + 1 >= NUM_QUEUES) ? '0 : grant_idx + QidWidth'(1);
    end
  end

  // Control registers.
  always_ff @(posedge axi_aclk) begin
    if (sw_rst) begin
      state_q   <= StIdle;
      start_q   <= 1'b0;
      out_q     <= '0;
      rr_q      <= '0;
      done_q    <= '0;
      cfg_err_q <= '0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_replay;
      out_q     <= out_d;
      rr_q      <= rr_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // Per-queue configuration and walk registers.
  always_ff @(posedge axi_aclk) begin
    if (sw_rst) begin
      for (int unsigned i = 0; i < NUM_QUEUES; i++) begin
        low_q[i]    <= '0;
        high_q[i]   <= '0;
        count_q[i]  <= '0;
        cur_q[i]    <= '0;
        passes_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_QUEUES; i++) begin
        if (state_q == StLoad) begin
          low_q[i]   <= q_addr_low[i*ADDR_WIDTH +: ADDR_WIDTH];
          high_q[i]  <= q_addr_high[i*ADDR_WIDTH +: ADDR_WIDTH];
          count_q[i] <= q_replay_count[i*COUNT_WIDTH +: COUNT_WIDTH];
        end
        cur_q[i]    <= cur_d[i];
        passes_q[i] <= passes_d[i];
      end
    end
  end

endmodule

// File: tb/tb_pcap_replay_sequencer.sv
// Directed bench for pcap_replay_sequencer with a 3-cycle response model.
module tb_pcap_replay_sequencer;

  localparam int unsigned NQ = 4;
  localparam int unsigned AW = 19;
  localparam int unsigned CW = 32;
  localparam int unsigned QW = 2;

  logic             clk = 1'b0;
  logic             sw_rst;
  logic             start_replay;
  logic [NQ-1:0]    q_enable;
  logic [NQ*AW-1:0] q_addr_low;
  logic [NQ*AW-1:0] q_addr_high;
  logic [NQ*CW-1:0] q_replay_count;
  logic             rd_req_valid;
  logic             rd_req_ready;
  logic [AW-1:0]    rd_req_addr;
  logic [QW-1:0]    rd_req_qid;
  logic             rd_rsp_valid;
  logic             busy;
  logic [NQ-1:0]    q_done;
  logic [NQ-1:0]    q_cfg_err;
  logic [NQ*CW-1:0] q_passes;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   acc_addr[$];
  int   acc_qid[$];
  logic [2:0] rsp_pipe;
  bit   auto_rsp;

  always #5 clk = ~clk;

  pcap_replay_sequencer dut (
    .axi_aclk       (clk),
    .sw_rst         (sw_rst),
    .start_replay   (start_replay),
    .q_enable       (q_enable),
    .q_addr_low     (q_addr_low),
    .q_addr_high    (q_addr_high),
    .q_replay_count (q_replay_count),
    .rd_req_valid   (rd_req_valid),
    .rd_req_ready   (rd_req_ready),
    .rd_req_addr    (rd_req_addr),
    .rd_req_qid     (rd_req_qid),
    .rd_rsp_valid   (rd_rsp_valid),
    .busy           (busy),
    .q_done         (q_done),
    .q_cfg_err      (q_cfg_err),
    .q_passes       (q_passes)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Log the handshake mid-cycle, advance one clock, then drive the response.
  task automatic cycle();
    @(negedge clk);
    if (rd_req_valid && rd_req_ready) begin
      acc_addr.push_back(int'(rd_req_addr));
      acc_qid.push_back(int'(rd_req_qid));
    end
    rsp_pipe = {rsp_pipe[1:0], rd_req_valid && rd_req_ready};
    @(posedge clk);
    #1;
    rd_rsp_valid = auto_rsp && rsp_pipe[2];
  endtask

  task automatic set_q(input int i, input int low, input int high, input int cnt);
    q_addr_low[i*AW +: AW]     = AW'(low);
    q_addr_high[i*AW +: AW]    = AW'(high);
    q_replay_count[i*CW +: CW] = CW'(cnt);
  endtask

  task automatic clear_run();
    acc_addr.delete();
    acc_qid.delete();
    rsp_pipe     = '0;
    rd_rsp_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      cycle();
      n++;
    end
    check(tag, busy, 1'b0);
  endtask

  task automatic end_run();
    start_replay = 1'b0;
    cycle();
    cycle();
  endtask

  initial begin
    int exp_a[8];
    int exp_q[8];
    int nz;
    logic [AW+QW:0] req_exp;

    sw_rst = 1'b1; start_replay = 1'b0; q_enable = '0;
    q_addr_low = '0; q_addr_high = '0; q_replay_count = '0;
    rd_req_ready = 1'b0; rd_rsp_valid = 1'b0; auto_rsp = 1'b0; rsp_pipe = '0;
    cycle();
    cycle();
    sw_rst = 1'b0;
    cycle();
    check("rst_valid", rd_req_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", q_done, '0);
    check("rst_err", q_cfg_err, '0);
    check("rst_passes", q_passes, '0);

    // Single queue, two passes over [0,8).
    q_enable = 4'b0001;
    set_q(0, 0, 8, 2);
    rd_req_ready = 1'b1; auto_rsp = 1'b1;
    clear_run();
    start_replay = 1'b1;
    cycle();
    check("t1_load_busy", busy, 1'b1);
    check("t1_load_valid", rd_req_valid, 1'b0);
    cycle();
    check("t1_first_valid", rd_req_valid, 1'b1);
    check("t1_first_addr", rd_req_addr, '0);
    wait_idle("t1_idle", 200);
    check("t1_count", acc_addr.size(), 8);
    for (int i = 0; i < 8 && i < acc_addr.size(); i++) begin
      check($sformatf("t1_addr%0d", i), acc_addr[i], (i % 4) * 2);
    end
    check("t1_passes", q_passes, 128'd2);
    check("t1_done", q_done, 4'b1111);
    check("t1_err", q_cfg_err, 4'b0000);
    end_run();

    // Four queues, one pass each: strict round-robin.
    q_enable = 4'b1111;
    set_q(0, 0, 4, 1);
    set_q(1, 100, 104, 1);
    set_q(2, 200, 204, 1);
    set_q(3, 300, 304, 1);
    exp_a = '{0, 100, 200, 300, 2, 102, 202, 302};
    exp_q = '{0, 1, 2, 3, 0, 1, 2, 3};
    clear_run();
    start_replay = 1'b1;
    cycle();
    wait_idle("t2_idle", 200);
    check("t2_count", acc_addr.size(), 8);
    for (int i = 0; i < 8 && i < acc_addr.size(); i++) begin
      check($sformatf("t2_qid%0d", i), acc_qid[i], exp_q[i]);
      check($sformatf("t2_addr%0d", i), acc_addr[i], exp_a[i]);
    end
    check("t2_passes", q_passes, {32'd1, 32'd1, 32'd1, 32'd1});
    check("t2_done", q_done, 4'b1111);
    end_run();

    // Credit limit, infinite queue 0, empty window on queue 1, then abort.
    q_enable = 4'b0011;
    set_q(0, 0, 4, 0);
    set_q(1, 50, 50, 1);
    auto_rsp = 1'b0;
    clear_run();
    start_replay = 1'b1;
    cycle();
    cycle();
    check("t3_cfg_err", q_cfg_err, 4'b0010);
    check("t3_done", q_done, 4'b1110);
    repeat (30) cycle();
    check("t3_credit_cnt", acc_addr.size(), 16);
    check("t3_credit_valid", rd_req_valid, 1'b0);
    check("t3_inf_passes", q_passes[31:0], 32'd8);
    nz = 0;
    foreach (acc_qid[i]) if (acc_qid[i] != 0) nz++;
    check("t3_q1_never", nz, 0);
    rd_rsp_valid = 1'b1;
    cycle();
    repeat (10) cycle();
    check("t3_one_more", acc_addr.size(), 17);
    check("t3_stall_again", rd_req_valid, 1'b0);
    start_replay = 1'b0;
    repeat (3) cycle();
    check("t3_abort_no_acc", acc_addr.size(), 17);
    check("t3_drain_busy", busy, 1'b1);
    repeat (16) begin
      rd_rsp_valid = 1'b1;
      cycle();
    end
    wait_idle("t3_idle", 10);
    cycle();
    check("t3_idle_valid", rd_req_valid, 1'b0);

    // Back-pressure: request held stable while ready is low.
    q_enable = 4'b0001;
    set_q(0, 0, 8, 1);
    rd_req_ready = 1'b0; auto_rsp = 1'b1;
    clear_run();
    start_replay = 1'b1;
    cycle();
    cycle();
    req_exp = {1'b1, 19'd0, 2'd0};
    for (int j = 0; j < 5; j++) begin
      check($sformatf("t4_hold%0d", j), {rd_req_valid, rd_req_addr, rd_req_qid}, req_exp);
      cycle();
    end
    check("t4_no_acc", acc_addr.size(), 0);
    rd_req_ready = 1'b1;
    wait_idle("t4_idle", 100);
    check("t4_count", acc_addr.size(), 4);
    for (int i = 0; i < 4 && i < acc_addr.size(); i++) begin
      check($sformatf("t4_addr%0d", i), acc_addr[i], i * 2);
    end
    end_run();

    // Reset in the middle of a run, with responses still in flight.
    set_q(0, 0, 4, 0);
    clear_run();
    start_replay = 1'b1;
    repeat (6) cycle();
    sw_rst = 1'b1;
    start_replay = 1'b0;
    cycle();
    check("t5_rst_out", {rd_req_valid, busy, q_done, q_cfg_err}, '0);
    check("t5_rst_passes", q_passes, '0);
    sw_rst = 1'b0;
    repeat (5) cycle();
    check("t5_after_busy", {rd_req_valid, busy}, 2'b00);
    set_q(0, 0, 4, 1);
    clear_run();
    start_replay = 1'b1;
    cycle();
    wait_idle("t5_rerun_idle", 100);
    check("t5_rerun_count", acc_addr.size(), 2);
    end_run();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
